fpu_req_sched: RTL and testbench
================================

Name: fpu_req_sched

Overview:
- Two-requester scheduler that shares one combinational FP16 add/mul datapath.
- Each requester presents operand A, operand B and an op bit over a valid/ready handshake.
- The block round-robin arbitrates between requesters, drives the shared datapath operands and holds them for a settle window.
- It then captures the selected result and valid flag, and returns them on a single tagged response channel.

Parameters:
- SETTLE_CYCLES, 1, cycles operands are held on the datapath before capture; legal range 1..15.
- OPS_W, 8, width of the completed-operation counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  16  requester 0 operand A (FP16)
- req0_b  in  16  requester 0 operand B (FP16)
- req0_op  in  1  requester 0 op: 1 = add, 0 = mul
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- dp_a  out  16  operand A to shared add/mul datapath
- dp_b  out  16  operand B to shared add/mul datapath
- dp_add_out  in  16  adder result
- dp_add_valid  in  1  adder valid flag
- dp_mul_out  in  16  multiplier result
- dp_mul_valid  in  1  multiplier valid flag
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes the response
- resp_id  out  1  requester index the response belongs to
- resp_result  out  16  captured result
- resp_flag  out  1  captured datapath valid flag
- busy  out  1  state != IDLE
- ops_done  out  OPS_W  count of completed response handshakes

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE; dp_a=dp_b=0; resp_valid=0; resp_id=0; resp_result=0; resp_flag=0; ops_done=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
  - Reset mid-operation drops the in-flight op silently; no response is produced.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant = requester with valid; if both are valid, the one != last_grant.
  - reqN_ready=1 combinationally only for the granted requester, only in IDLE; both readies are 0 in every other state.
  - On handshake edge: dp_a/dp_b <= granted operands; latch op and id; last_grant <= id; settle counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - On the edge where counter==0: resp_result <= op ? dp_add_out : dp_mul_out; resp_flag <= op ? dp_add_valid : dp_mul_valid; resp_id <= latched id; resp_valid <= 1; go to RESP.
- RESP:
  - resp_* held stable while resp_valid && !resp_ready.
  - On the resp_ready edge: resp_valid <= 0; ops_done <= ops_done+1 (wraps modulo 2^OPS_W); go to IDLE.
  - resp_result, resp_flag and resp_id keep their last value after the handshake.
- Latency:
  - Accept at edge E0 → resp_valid high after edge E0+SETTLE_CYCLES.
  - With resp_ready held 1, the next accept is possible at E0+SETTLE_CYCLES+2.
  - Minimum period is SETTLE_CYCLES+2 cycles per op.
- dp_a/dp_b are registered and hold their value until the next accept; they are never cleared except by reset.
- The datapath is purely combinational and is sampled only at the capture edge; changes on dp_* inputs at other times are ignored.
- Requesters must hold valid and payload until ready. A valid dropped before grant is not an error: no grant, no state change.
- Simultaneous req0_valid and req1_valid: strict alternation under continuous load (0,1,0,1…).
- A single active requester is granted every opportunity; last_grant does not block it.
- The resp_ready level before resp_valid is ignored.

Decomposition:
- Package fpu_sched_pkg:
  - state enum (IDLE, SETTLE, RESP).
  - op constants OP_MUL=1'b0, OP_ADD=1'b1.
  - FP16 width constant FP_W=16.
- Sub-module rr_arb2: combinational two-way round-robin grant from {valid0, valid1, last_grant} → {grant_valid, grant_id}.
- Pointer register stays in fpu_req_sched.

Test Plan:
- Reset then req0 add, a=0x3C00, b=0x4000, datapath model (dp_add_out = FP16 sum): resp_valid rises 1 cycle after accept (SETTLE_CYCLES=1) with resp_id=0, resp_result=0x4200, resp_flag=1; ops_done=1 after handshake.
- req1 mul, a=0x4000, b=0x4200 → resp_id=1, resp_result=0x4600; req1_ready pulses exactly one cycle; req0_ready stays 0 throughout.
- Both requesters valid continuously for 6 ops, resp_ready=1 → grant order 0,1,0,1,0,1; one accept every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles → resp_* stable and both readies 0; then resp_ready=1 → single handshake, ops_done +1, IDLE next cycle.
- Reset asserted during SETTLE → next cycle resp_valid=0, busy=0, dp_a=0; next dual request is granted to requester 0.
- SETTLE_CYCLES=3 build with dp_mul_valid=0 injected → resp_valid 3 cycles after accept, resp_flag=0; 256 ops make ops_done wrap to 0.

Source files
------------

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types and constants for the FP16 request scheduler.
// Provides the FSM state type, op encodings and the FP16 word width.
package fpu_sched_pkg;

    localparam int FP_W = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// Ports: valid0/valid1 requests, last_grant pointer -> grant_valid, grant_id.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Contention goes to whoever was not served last; a lone
    // requester always wins regardless of the pointer.
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1)
            grant_id = ~last_grant;
        else if (valid1)
            grant_id = 1'b1;
    end

endmodule

// File: rtl/fpu_req_sched.sv
// fpu_req_sched: round-robin scheduler sharing one FP16 add/mul datapath.
// Ports: req0/req1 valid-ready ops in, dp_* datapath link, resp_* out.
module fpu_req_sched
    import fpu_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int OPS_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FP_W-1:0]  req0_a,
    input  logic [FP_W-1:0]  req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FP_W-1:0]  req1_a,
    input  logic [FP_W-1:0]  req1_b,
    input  logic             req1_op,
    output logic [FP_W-1:0]  dp_a,
    output logic [FP_W-1:0]  dp_b,
    input  logic [FP_W-1:0]  dp_add_out,
    input  logic             dp_add_valid,
    input  logic [FP_W-1:0]  dp_mul_out,
    input  logic             dp_mul_valid,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [FP_W-1:0]  resp_result,
    output logic             resp_flag,
    output logic             busy,
    output logic [OPS_W-1:0] ops_done
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       last_grant;
    logic       op_q;
    logic       id_q;
    logic       gnt_v;
    logic       gnt_id;
    logic       accept;
    logic       capture;
    logic       done;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant),
        .grant_valid (gnt_v),
        .grant_id    (gnt_id)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = gnt_v & ~gnt_id;
                req1_ready = gnt_v & gnt_id;
                accept     = gnt_v;
                if (gnt_v)
                    state_nx = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dp_a        <= '0;
            dp_b        <= '0;
            cnt         <= 4'd0;
            op_q        <= OP_MUL;
            id_q        <= 1'b0;
            last_grant  <= 1'b1;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flag   <= 1'b0;
            ops_done    <= '0;
        end else begin
            if (accept) begin
                dp_a       <= gnt_id ? req1_a : req0_a;
                dp_b       <= gnt_id ? req1_b : req0_b;
                op_q       <= gnt_id ? req1_op : req0_op;
                id_q       <= gnt_id;
                last_grant <= gnt_id;
                cnt        <= CNT_INIT;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Datapath is only looked at on this one edge.
            if (capture) begin
                resp_result <= (op_q == OP_ADD) ? dp_add_out
                                                : dp_mul_out;
                resp_flag   <= (op_q == OP_ADD) ? dp_add_valid
                                                : dp_mul_valid;
                resp_id     <= id_q;
                resp_valid  <= 1'b1;
            end
            if (done) begin
                resp_valid <= 1'b0;
                ops_done   <= ops_done + OPS_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fpu_req_sched.sv
// tb_fpu_req_sched: randomized and directed checks of fpu_req_sched
// against a transaction-timing reference model (SETTLE 1 and 3 builds).
module tb_fpu_req_sched;

    localparam int S  = 1;
    localparam int SB = 3;

    // Stand-in datapath: exact FP16 results for the directed operands,
    // a cheap scramble elsewhere (the scheduler does not care).
    function automatic logic [15:0] add_f(input logic [15:0] a,
                                          input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        return (a ^ {b[7:0], b[15:8]}) + 16'h0101;
    endfunction

    function automatic logic [15:0] mul_f(input logic [15:0] a,
                                          input logic [15:0] b);
        if (a == 16'h4000 && b == 16'h4200) return 16'h4600;
        return (a + b) ^ 16'h5A5A;
    endfunction

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        r0v = 1'b0, r0op = 1'b0, r1v = 1'b0, r1op = 1'b0;
    logic        rrdy = 1'b0;
    logic [15:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic        rdy0, rdy1, rv, rid, rflag, busy;
    logic [15:0] dpa, dpb, rres;
    logic [7:0]  ops;
    logic [15:0] add_o, mul_o;
    logic        add_v, mul_v;

    assign add_o = add_f(dpa, dpb);
    assign mul_o = mul_f(dpa, dpb);
    assign add_v = ^{dpa, dpb};
    assign mul_v = ~^{dpa, dpb};

    fpu_req_sched #(.SETTLE_CYCLES(S), .OPS_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .req0_valid(r0v), .req0_ready(rdy0), .req0_a(r0a),
        .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(rdy1), .req1_a(r1a),
        .req1_b(r1b), .req1_op(r1op),
        .dp_a(dpa), .dp_b(dpb),
        .dp_add_out(add_o), .dp_add_valid(add_v),
        .dp_mul_out(mul_o), .dp_mul_valid(mul_v),
        .resp_valid(rv), .resp_ready(rrdy), .resp_id(rid),
        .resp_result(rres), .resp_flag(rflag),
        .busy(busy), .ops_done(ops)
    );

    // Second build: longer settle window, multiplier flag forced low.
    logic        b_rst = 1'b1, b_v = 1'b0, b_op = 1'b0, b_rrdy = 1'b0;
    logic [15:0] b_a = '0, b_b = '0;
    logic        b_r1v = 1'b0, b_r1op = 1'b0;
    logic [15:0] b_r1a = '0, b_r1b = '0;
    logic        b_rdy0, b_rdy1, b_rv, b_rid, b_flag, b_busy;
    logic [15:0] b_dpa, b_dpb, b_res, b_add_o, b_mul_o;
    logic [7:0]  b_ops;
    logic        b_add_v = 1'b1, b_mul_v = 1'b0;

    assign b_add_o = add_f(b_dpa, b_dpb);
    assign b_mul_o = mul_f(b_dpa, b_dpb);

    fpu_req_sched #(.SETTLE_CYCLES(SB), .OPS_W(8)) u_dut3 (
        .clock(clock), .reset(b_rst),
        .req0_valid(b_v), .req0_ready(b_rdy0), .req0_a(b_a),
        .req0_b(b_b), .req0_op(b_op),
        .req1_valid(b_r1v), .req1_ready(b_rdy1), .req1_a(b_r1a),
        .req1_b(b_r1b), .req1_op(b_r1op),
        .dp_a(b_dpa), .dp_b(b_dpb),
        .dp_add_out(b_add_o), .dp_add_valid(b_add_v),
        .dp_mul_out(b_mul_o), .dp_mul_valid(b_mul_v),
        .resp_valid(b_rv), .resp_ready(b_rrdy), .resp_id(b_rid),
        .resp_result(b_res), .resp_flag(b_flag),
        .busy(b_busy), .ops_done(b_ops)
    );

    int n_chk = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: scheduler is free or holding one op; a held op's
    // response becomes visible SETTLE cycles after its accept edge.
    bit          known = 0, m_free, m_pend, m_last, rv_prev = 0;
    int          m_at, m_ops, rise_cyc = 0;
    logic        m_id, m_flag, m_lid, m_lflag;
    logic [15:0] m_res, m_lres, m_dpa, m_dpb;
    int          n_rdy0 = 0, n_rdy1 = 0;
    int          acc_id[$], acc_cyc[$], h_res[$], h_id[$], h_flag[$];

    task automatic model_reset();
        m_free = 1; m_pend = 0; m_last = 1; m_ops = 0;
        m_id = 0; m_flag = 0; m_res = '0;
        m_lid = 0; m_lflag = 0; m_lres = '0;
        m_dpa = '0; m_dpb = '0;
    endtask

    task automatic step();
        bit          gv, vis;
        logic        gid, op;
        logic [15:0] a, b;
        #1;
        gv  = m_free && (r0v || r1v);
        gid = (r0v && r1v) ? ~m_last : r1v;
        vis = m_pend && (cyc >= m_at);
        if (rdy0 === 1'b1) n_rdy0++;
        if (rdy1 === 1'b1) n_rdy1++;
        if (known) begin
            chk("rdy0", rdy0, gv && !gid);
            chk("rdy1", rdy1, gv && gid);
            chk("busy", busy, !m_free);
            chk("resp_valid", rv, vis);
            chk("dp_a", dpa, m_dpa);
            chk("dp_b", dpb, m_dpb);
            chk("ops_done", ops, m_ops);
            chk("resp_id", rid, vis ? m_id : m_lid);
            chk("resp_result", rres, vis ? m_res : m_lres);
            chk("resp_flag", rflag, vis ? m_flag : m_lflag);
            if (rv === 1'b1 && !rv_prev) rise_cyc = cyc;
            rv_prev = (rv === 1'b1);
        end
        if (reset) begin
            model_reset();
            known = 1;
            gv = 0;
        end else if (gv) begin
            a  = gid ? r1a : r0a;
            b  = gid ? r1b : r0b;
            op = gid ? r1op : r0op;
            m_free = 0; m_pend = 1; m_id = gid; m_last = gid;
            m_dpa = a; m_dpb = b;
            m_res  = op ? add_f(a, b) : mul_f(a, b);
            m_flag = op ? ^{a, b} : ~^{a, b};
            m_at   = cyc + 1 + S;
            acc_id.push_back(int'(gid));
            acc_cyc.push_back(cyc);
        end else if (vis && rrdy) begin
            h_res.push_back(int'(rres));
            h_id.push_back(int'(rid));
            h_flag.push_back(int'(rflag));
            m_pend = 0; m_free = 1;
            m_ops  = (m_ops + 1) % 256;
            m_lres = m_res; m_lid = m_id; m_lflag = m_flag;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (gv) begin
            if (gid) r1v = 1'b0;
            else     r0v = 1'b0;
        end
    endtask

    task automatic settle_all();
        for (int i = 0; i < 40; i++) begin
            if (!r0v && !r1v && m_free) break;
            step();
        end
        chk("settle_idle", busy, 0);
    endtask

    task automatic clear_logs();
        acc_id.delete(); acc_cyc.delete();
        h_res.delete(); h_id.delete(); h_flag.delete();
        n_rdy0 = 0; n_rdy1 = 0;
    endtask

    int          sops, n;
    logic [15:0] snap, ba, bb;

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        step();
        step();
        reset = 1'b0;
        chk("rst_resp_valid", rv, 0);
        chk("rst_ops", ops, 0);

        // Contention under continuous load: strict alternation.
        clear_logs();
        rrdy = 1'b1;
        for (int i = 0; i < 40 && acc_id.size() < 6; i++) begin
            if (!r0v) begin
                r0v = 1; r0a = 16'($urandom); r0b = 16'($urandom);
                r0op = 1'($urandom);
            end
            if (!r1v) begin
                r1v = 1; r1a = 16'($urandom); r1b = 16'($urandom);
                r1op = 1'($urandom);
            end
            step();
        end
        r0v = 0; r1v = 0;
        chk("alt_count", acc_id.size(), 6);
        for (int i = 0; i < 6 && i < acc_id.size(); i++) begin
            chk("alt_order", acc_id[i], i % 2);
            if (i > 0) chk("alt_period", acc_cyc[i] - acc_cyc[i-1], S + 2);
        end
        settle_all();

        // req0 add 1.0 + 2.0
        clear_logs();
        r0v = 1; r0a = 16'h3C00; r0b = 16'h4000; r0op = 1'b1;
        settle_all();
        chk("add_n", h_res.size(), 1);
        if (h_res.size() > 0) begin
            chk("add_result", h_res[0], 16'h4200);
            chk("add_id", h_id[0], 0);
            chk("add_flag", h_flag[0], 1);
        end
        // visible S cycles after the accept edge (one after ready cycle)
        if (acc_cyc.size() > 0)
            chk("add_latency", rise_cyc - acc_cyc[0], S + 1);
        chk("add_ops", ops, 7);

        // req1 mul 2.0 * 3.0
        clear_logs();
        r1v = 1; r1a = 16'h4000; r1b = 16'h4200; r1op = 1'b0;
        settle_all();
        chk("mul_rdy1_pulses", n_rdy1, 1);
        chk("mul_rdy0_pulses", n_rdy0, 0);
        if (h_res.size() > 0) begin
            chk("mul_result", h_res[0], 16'h4600);
            chk("mul_id", h_id[0], 1);
        end

        // Backpressure
        clear_logs();
        rrdy = 0;
        r0v = 1; r0a = 16'h1234; r0b = 16'h5678; r0op = 1'b1;
        for (int i = 0; i < 10 && rv !== 1'b1; i++) step();
        chk("bp_valid", rv, 1);
        snap = rres; sops = int'(ops);
        n_rdy0 = 0; n_rdy1 = 0;
        r0v = 1; r0a = 16'hAAAA; r1v = 1; r1a = 16'h5555;
        repeat (5) step();
        chk("bp_hold", rres, snap);
        chk("bp_rdy", n_rdy0 + n_rdy1, 0);
        chk("bp_ops", ops, sops);
        rrdy = 1; r0v = 0; r1v = 0;
        step();
        chk("bp_busy", busy, 0);
        chk("bp_ops_inc", ops, (sops + 1) % 256);
        chk("bp_valid_low", rv, 0);
        settle_all();

        // Reset while an op is settling
        clear_logs();
        r0v = 1; r0a = 16'hBEEF; r0b = 16'h0101; r0op = 1'b0;
        for (int i = 0; i < 5 && acc_id.size() == 0; i++) step();
        chk("rs_busy_before", busy, 1);
        reset = 1;
        step();
        reset = 0;
        chk("rs_valid", rv, 0);
        chk("rs_busy", busy, 0);
        chk("rs_dp_a", dpa, 0);
        clear_logs();
        r0v = 1; r1v = 1;
        step();
        chk("rs_grant_n", acc_id.size(), 1);
        if (acc_id.size() > 0) chk("rs_grant_id", acc_id[0], 0);
        settle_all();

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            if (!r0v && $urandom % 3 == 0) begin
                r0v = 1; r0a = 16'($urandom); r0b = 16'($urandom);
                r0op = 1'($urandom);
            end else if (r0v && $urandom % 20 == 0) begin
                r0v = 0;
            end
            if (!r1v && $urandom % 3 == 0) begin
                r1v = 1; r1a = 16'($urandom); r1b = 16'($urandom);
                r1op = 1'($urandom);
            end else if (r1v && $urandom % 20 == 0) begin
                r1v = 0;
            end
            rrdy  = ($urandom % 4) != 0;
            reset = ($urandom % 300) == 0;
            step();
        end
        reset = 0; rrdy = 1;
        settle_all();

        // SETTLE_CYCLES=3 build, mul flag low, counter wrap
        @(posedge clock); #1;
        b_rst = 0; b_rrdy = 1;
        chk("b_rst_ops", b_ops, 0);
        chk("b_rst_valid", b_rv, 0);
        for (int i = 0; i < 256; i++) begin
            ba = 16'($urandom); bb = 16'($urandom);
            b_a = ba; b_b = bb; b_op = 1'b0; b_v = 1'b1;
            #1;
            chk("b_ready", b_rdy0, 1);
            @(posedge clock); #1;
            b_v = 1'b0;
            n = 0;
            while (b_rv !== 1'b1 && n < 10) begin
                @(posedge clock); #1;
                n++;
            end
            chk("b_latency", n, SB);
            chk("b_result", b_res, mul_f(ba, bb));
            chk("b_flag", b_flag, 0);
            chk("b_id", b_rid, 0);
            @(posedge clock); #1;
            chk("b_ops", b_ops, (i + 1) % 256);
            chk("b_valid_low", b_rv, 0);
        end
        chk("b_wrap", b_ops, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
